// File: rtl/mpu_alu_pkg.sv
// Shared definitions for the bit-serial ALU: operation codes and FSM state encoding.
package mpu_alu_pkg;

  localparam logic [2:0] OP_AND  = 3'b000;
  localparam logic [2:0] OP_OR   = 3'b001;
  localparam logic [2:0] OP_XOR  = 3'b010;
  localparam logic [2:0] OP_NAND = 3'b011;
  localparam logic [2:0] OP_NOR  = 3'b100;
  localparam logic [2:0] OP_NOTA = 3'b101;
  localparam logic [2:0] OP_ADD  = 3'b110;
  localparam logic [2:0] OP_SUB  = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // ADD and SUB are the only ops that use the carry chain.
  function automatic logic is_arith(input logic [2:0] op);
    return (op == OP_ADD) || (op == OP_SUB);
  endfunction

endpackage

// File: rtl/serial_alu_if.sv
// Operand/result bundle between the requester and the serial ALU.
interface serial_alu_if #(parameter int WIDTH = 8);
  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             carry;
  logic             zero;

  modport master (output start, op, a, b, input busy, done, result, carry, zero);
  modport slave  (input start, op, a, b, output busy, done, result, carry, zero);
endinterface

// File: rtl/serial_alu_slice.sv
// Combinational one-bit ALU slice built from gate primitives; b is inverted here for SUB.
module serial_alu_slice
  import mpu_alu_pkg::*;
(
  input  logic       a_bit,
  input  logic       b_bit,
  input  logic       cin,
  input  logic [2:0] op,
  output logic       r_bit,
  output logic       cout
);

  logic is_sub_s;
  logic b_eff_s;
  logic and_s, or_s, xor_s, nand_s, nor_s, nota_s;
  logic hx_s, sum_s, c1_s, c2_s;

  assign is_sub_s = (op == OP_SUB);

  xor  u_binv (b_eff_s, b_bit, is_sub_s);
  and  u_and  (and_s,  a_bit, b_bit);
  or   u_or   (or_s,   a_bit, b_bit);
  xor  u_xor  (xor_s,  a_bit, b_bit);
  nand u_nand (nand_s, a_bit, b_bit);
  nor  u_nor  (nor_s,  a_bit, b_bit);
  not  u_nota (nota_s, a_bit);

  // Full adder on the (possibly inverted) b bit.
  xor  u_fa_x1 (hx_s,  a_bit, b_eff_s);
  xor  u_fa_x2 (sum_s, hx_s,  cin);
  and  u_fa_a1 (c1_s,  a_bit, b_eff_s);
  and  u_fa_a2 (c2_s,  hx_s,  cin);
  or   u_fa_o1 (cout,  c1_s,  c2_s);

  // Result bit select by operation.
  always_comb begin
    r_bit = 1'b0;
    case (op)
      OP_AND:  r_bit = and_s;
      OP_OR:   r_bit = or_s;
      OP_XOR:  r_bit = xor_s;
      OP_NAND: r_bit = nand_s;
      OP_NOR:  r_bit = nor_s;
      OP_NOTA: r_bit = nota_s;
      OP_ADD:  r_bit = sum_s;
      OP_SUB:  r_bit = sum_s;
      default: r_bit = 1'b0;
    endcase
  end

endmodule

// File: rtl/serial_alu.sv
// Bit-serial ALU: captures operands on start, processes one bit per clock LSB first,
// and registers result/carry/zero with a one-cycle done pulse.
module serial_alu
  import mpu_alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic         clk,
  input  logic         rst,
  serial_alu_if.slave  bus
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state_r, state_nx;
  logic [CW-1:0]    cnt_r;
  logic [WIDTH-1:0] a_r, b_r, acc_r, result_r;
  logic [2:0]       op_r;
  logic             cy_r, carry_r, zero_r, busy_r, done_r;
  logic             accept_s, last_s;
  logic             r_bit_s, cout_s;
  logic [WIDTH-1:0] acc_nx_s;

  serial_alu_slice u_slice (
    .a_bit (a_r[0]),
    .b_bit (b_r[0]),
    .cin   (cy_r),
    .op    (op_r),
    .r_bit (r_bit_s),
    .cout  (cout_s)
  );

  assign acc_nx_s = {r_bit_s, acc_r[WIDTH-1:1]};

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nx;
    end
  end

  // Next-state decode plus accept / final-step strobes.
  always_comb begin
    state_nx = state_r;
    accept_s = 1'b0;
    last_s   = 1'b0;
    case (state_r)
      IDLE: begin
        if (bus.start) begin
          state_nx = RUN;
          accept_s = 1'b1;
        end else begin
          state_nx = IDLE;
        end
      end
      RUN: begin
        if (cnt_r == LAST) begin
          state_nx = DONE;
          last_s   = 1'b1;
        end else begin
          state_nx = RUN;
        end
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Operand shift registers, bit counter, carry chain and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r    <= {CW{1'b0}};
      a_r      <= {WIDTH{1'b0}};
      b_r      <= {WIDTH{1'b0}};
      op_r     <= 3'b000;
      acc_r    <= {WIDTH{1'b0}};
      cy_r     <= 1'b0;
      result_r <= {WIDTH{1'b0}};
      carry_r  <= 1'b0;
      zero_r   <= 1'b0;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
    end else begin
      busy_r <= (state_nx == RUN);
      done_r <= last_s;
      if (accept_s) begin
        a_r   <= bus.a;
        b_r   <= bus.b;
        op_r  <= bus.op;
        cnt_r <= {CW{1'b0}};
        // SUB is a + ~b + 1: the +1 enters as the initial carry.
        cy_r  <= (bus.op == OP_SUB);
      end else if (state_r == RUN) begin
        a_r   <= {1'b0, a_r[WIDTH-1:1]};
        b_r   <= {1'b0, b_r[WIDTH-1:1]};
        acc_r <= acc_nx_s;
        cnt_r <= cnt_r + CW'(1);
        cy_r  <= is_arith(op_r) ? cout_s : 1'b0;
        if (last_s) begin
          result_r <= acc_nx_s;
          carry_r  <= is_arith(op_r) ? cout_s : 1'b0;
          zero_r   <= (acc_nx_s == {WIDTH{1'b0}});
        end
      end
    end
  end

  assign bus.busy   = busy_r;
  assign bus.done   = done_r;
  assign bus.result = result_r;
  assign bus.carry  = carry_r;
  assign bus.zero   = zero_r;

endmodule

// File: tb/tb_serial_alu.sv
// Directed, table-driven bench for serial_alu plus hand-written multi-cycle sequences.
module tb_serial_alu;
  import mpu_alu_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  serial_alu_if #(.WIDTH(8)) bus ();

  serial_alu #(.WIDTH(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] res;
    logic       carry;
    logic       zero;
  } vec_t;

  vec_t vecs [11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Starts at the sample just after the accept edge; counts busy cycles until done.
  task automatic wait_done(output int cyc, output int bc);
    cyc = 0;
    bc  = 0;
    while (!bus.done && cyc < 20) begin
      if (bus.busy) bc++;
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic do_op(input string nm, input logic [2:0] op, input logic [7:0] a,
                       input logic [7:0] b, input logic [7:0] er, input logic ec,
                       input logic ez);
    int cyc, bc;
    @(negedge clk);
    bus.start = 1'b1; bus.op = op; bus.a = a; bus.b = b;
    @(negedge clk);
    bus.start = 1'b0;
    wait_done(cyc, bc);
    chk({nm, " latency"}, cyc, 32'd8);
    chk({nm, " busy_cycles"}, bc, 32'd8);
    chk({nm, " result"}, {24'd0, bus.result}, {24'd0, er});
    chk({nm, " carry"}, {31'd0, bus.carry}, {31'd0, ec});
    chk({nm, " zero"}, {31'd0, bus.zero}, {31'd0, ez});
    @(negedge clk);
    chk({nm, " done_pulse_width"}, {31'd0, bus.done}, 32'd0);
  endtask

  initial begin
    int cyc, bc, dc, last_done, n;
    logic [7:0] bb_res [3];

    vecs[0]  = '{OP_ADD,  8'h3C, 8'h0F, 8'h4B, 1'b0, 1'b0};
    vecs[1]  = '{OP_ADD,  8'hFF, 8'h01, 8'h00, 1'b1, 1'b1};
    vecs[2]  = '{OP_SUB,  8'h07, 8'h05, 8'h02, 1'b1, 1'b0};
    vecs[3]  = '{OP_SUB,  8'h05, 8'h07, 8'hFE, 1'b0, 1'b0};
    vecs[4]  = '{OP_SUB,  8'h05, 8'h05, 8'h00, 1'b1, 1'b1};
    vecs[5]  = '{OP_AND,  8'hF0, 8'hCC, 8'hC0, 1'b0, 1'b0};
    vecs[6]  = '{OP_OR,   8'hF0, 8'hCC, 8'hFC, 1'b0, 1'b0};
    vecs[7]  = '{OP_XOR,  8'hF0, 8'hCC, 8'h3C, 1'b0, 1'b0};
    vecs[8]  = '{OP_NAND, 8'hF0, 8'hCC, 8'h3F, 1'b0, 1'b0};
    vecs[9]  = '{OP_NOR,  8'hF0, 8'hCC, 8'h03, 1'b0, 1'b0};
    vecs[10] = '{OP_NOTA, 8'hA5, 8'h00, 8'h5A, 1'b0, 1'b0};

    bus.start = 1'b0; bus.op = 3'b000; bus.a = 8'h00; bus.b = 8'h00;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("reset result", {24'd0, bus.result}, 32'd0);
    chk("reset flags", {27'd0, bus.busy, bus.done, bus.carry, bus.zero, 1'b0}, 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 11; i++) begin
      do_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b,
            vecs[i].res, vecs[i].carry, vecs[i].zero);
    end

    // start held high with inputs churning; only one done, next accept at E10.
    @(negedge clk);
    bus.start = 1'b1; bus.op = OP_ADD; bus.a = 8'h01; bus.b = 8'h01;
    dc = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (bus.done) begin
        dc++;
        chk("hold result", {24'd0, bus.result}, 32'h02);
        chk("hold carry", {31'd0, bus.carry}, 32'd0);
      end
      bus.op = 3'(k);
      bus.a  = 8'(8'h11 * k);
      bus.b  = 8'(8'h3B + k);
    end
    chk("hold done_count", dc, 32'd1);
    chk("hold idle_before_accept", {31'd0, bus.busy}, 32'd0);
    bus.op = OP_AND; bus.a = 8'hF0; bus.b = 8'hCC;
    @(negedge clk);
    chk("hold accept_in_idle", {31'd0, bus.busy}, 32'd1);
    bus.start = 1'b0;
    wait_done(cyc, bc);
    chk("hold next latency", cyc, 32'd8);
    chk("hold next result", {24'd0, bus.result}, 32'hC0);

    // Reset during bit 4 of an ADD.
    @(negedge clk);
    bus.start = 1'b1; bus.op = OP_ADD; bus.a = 8'h3C; bus.b = 8'h0F;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort result", {24'd0, bus.result}, 32'd0);
    chk("abort flags", {28'd0, bus.busy, bus.done, bus.carry, bus.zero}, 32'd0);
    dc = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (bus.done) dc++;
    end
    chk("abort no_done", dc, 32'd0);
    do_op("post_abort", OP_ADD, 8'h10, 8'h20, 8'h30, 1'b0, 1'b0);

    // Back-to-back with start high throughout.
    bb_res[0] = 8'h03; bb_res[1] = 8'h0F; bb_res[2] = 8'h33;
    @(negedge clk);
    bus.start = 1'b1; bus.op = OP_ADD; bus.a = 8'h01; bus.b = 8'h02;
    n = 0;
    last_done = -1;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (bus.done && n < 3) begin
        chk($sformatf("b2b result%0d", n), {24'd0, bus.result}, {24'd0, bb_res[n]});
        if (last_done >= 0) chk($sformatf("b2b spacing%0d", n), c - last_done, 32'd10);
        last_done = c;
        n++;
        case (n)
          1: begin bus.op = OP_SUB; bus.a = 8'h10; bus.b = 8'h01; end
          2: begin bus.op = OP_OR;  bus.a = 8'h30; bus.b = 8'h03; end
          default: bus.start = 1'b0;
        endcase
      end else if (n > 0 && n < 3) begin
        chk("b2b held", {24'd0, bus.result}, {24'd0, bb_res[n-1]});
      end
    end
    chk("b2b done_count", n, 32'd3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
